// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 key schedule: sizes, round-key
// type, controller state encoding, rcon table and the AES S-box.
package aes_pkg;

  localparam int NR        = 10;
  localparam int KW        = 128;
  localparam int EXP_KEY_W = (NR + 1) * KW;

  typedef logic [KW-1:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Round constants, meaningful for rounds 1..10; other indices yield 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  // S-box: field inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_key_step.sv
// One AES-128 key-expansion step: previous round key and round index in,
// next round key out. Purely combinational.
module aes_round_key_step
  import aes_pkg::*;
(
  input  round_key_t  prev_key,
  input  logic [3:0]  round_idx,
  output round_key_t  next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign temp = sub ^ {rcon(round_idx), 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one expansion step reused over
// NR cycles to fill an 11-entry round-key store, exposed as a flat bus and
// through a registered indexed read port.
// Optional build macro AES_KEY_CACHE_EN: re-offering the stored key in DONE
// keeps the schedule and pulses cache_hit instead of re-expanding.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [127:0]     key_in,
  output logic             busy,
  output logic             rk_valid,
  output logic [1407:0]    expanded_key,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [127:0]     rd_data,
  output logic             rd_data_valid,
  output logic             rd_err
`ifdef AES_KEY_CACHE_EN
  ,
  output logic             cache_hit
`endif
);

  if (NR != 10 || KW != 128) begin : g_param_check
    $fatal(1, "aes_key_sched_ctrl supports only NR=10 and KW=128");
  end

  state_t      state, state_next;
  logic [3:0]  round_cnt;
  round_key_t  store [0:10];
  round_key_t  prev_key, step_key, rd_word;
  logic        accept, hit, reload, readable;

  assign accept = key_valid && (state == IDLE || state == DONE);

`ifdef AES_KEY_CACHE_EN
  assign hit = accept && (state == DONE) && (key_in == store[0]);
`else
  assign hit = 1'b0;
`endif

  assign reload = accept && !hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs derived from the current state.
  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    busy       = 1'b0;
    rk_valid   = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (reload) state_next = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (round_cnt == 4'd10) state_next = DONE;
      end
      DONE: begin
        key_ready = 1'b1;
        rk_valid  = 1'b1;
        if (reload) state_next = EXPAND;
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the previously written round key as the step input.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++) begin
      if (round_cnt == 4'(i + 1)) prev_key = store[i];
    end
  end

  aes_round_key_step u_step (
    .prev_key  (prev_key),
    .round_idx (round_cnt),
    .next_key  (step_key)
  );

  // Round-key store and round counter: load RK0 on accept, one key per cycle in EXPAND.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt <= '0;
      for (int i = 0; i <= 10; i++) store[i] <= '0;
    end else if (reload) begin
      store[0]  <= key_in;
      round_cnt <= 4'd1;
    end else if (state == EXPAND) begin
      for (int i = 1; i <= 10; i++) begin
        if (round_cnt == 4'(i)) store[i] <= step_key;
      end
      round_cnt <= round_cnt + 4'd1;
    end
  end

  for (genvar g = 0; g <= 10; g++) begin : g_flat
    assign expanded_key[128*g +: 128] = store[g];
  end

  // Read-port mux and readability: an entry is readable once written.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rd_idx == 4'(i)) rd_word = store[i];
    end
    readable = (rd_idx <= 4'd10) &&
               ((state == DONE) || ((state == EXPAND) && (rd_idx < round_cnt)));
  end

  // Registered read response, sampled from the pre-update store.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
    end else if (rd_en) begin
      if (readable) begin
        rd_data       <= rd_word;
        rd_data_valid <= 1'b1;
        rd_err        <= 1'b0;
      end else begin
        rd_data       <= '0;
        rd_data_valid <= 1'b0;
        rd_err        <= 1'b1;
      end
    end else begin
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
    end
  end

`ifdef AES_KEY_CACHE_EN
  // One-cycle pulse when a re-offered key matches the stored schedule.
  always_ff @(posedge clk) begin
    if (rst) cache_hit <= 1'b0;
    else     cache_hit <= hit;
  end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: FIPS-197 vector table, hand
// sequences for hold/read/reset corners, and random keys against a word-level
// key-expansion model.
module tb_aes_key_sched_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            key_valid;
  logic            key_ready;
  logic [127:0]    key_in;
  logic            busy;
  logic            rk_valid;
  logic [1407:0]   expanded_key;
  logic            rd_en;
  logic [3:0]      rd_idx;
  logic [127:0]    rd_data;
  logic            rd_data_valid;
  logic            rd_err;
`ifdef AES_KEY_CACHE_EN
  logic            cache_hit;
`endif

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key_in        (key_in),
    .busy          (busy),
    .rk_valid      (rk_valid),
    .expanded_key  (expanded_key),
    .rd_en         (rd_en),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_err        (rd_err)
`ifdef AES_KEY_CACHE_EN
    ,
    .cache_hit     (cache_hit)
`endif
  );

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK2  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
  localparam logic [127:0] FIPS_RK3  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] OTHER_KEY = 128'h00112233_44556677_8899aabb_ccddeeff;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp_data;
    logic         exp_valid;
    logic         exp_err;
  } rd_vec_t;

  int total  = 0;
  int passed = 0;

  logic [7:0]   sbox_m   [0:255];
  logic [127:0] model_rk [0:10];

  // Shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, bb;
    p  = 8'h00;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) p = p ^ bb;
      bb = bb[7] ? ({bb[6:0], 1'b0} ^ 8'h1b) : {bb[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box built by brute-force inverse search plus bitwise affine transform.
  task automatic buildSbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_m[x] = s;
    end
  endtask

  // Word-oriented AES-128 key expansion (44 words).
  task automatic modelExpand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic kv, input logic [127:0] k,
                               input logic re, input logic [3:0] idx);
    key_valid = kv;
    key_in    = k;
    rd_en     = re;
    rd_idx    = idx;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Accept a key from DONE/IDLE and wait (bounded) for rk_valid; lat counts edges after accept.
  task automatic loadKey(input logic [127:0] k, output int lat);
    applyStimulus(1'b1, k, 1'b0, 4'd0);
    tick();
    key_valid = 1'b0;
    lat = 0;
    while (rk_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic checkSchedule(input string name);
    for (int r = 0; r <= 10; r++) begin
      checkOutput($sformatf("%s_rk%0d", name, r), expanded_key[128*r +: 128], model_rk[r]);
    end
  endtask

  initial begin
    rd_vec_t      vecs [8];
    logic [127:0] key, last_key;
    int           lat, kr_low;
    int           ridx;

    vecs[0] = '{4'd0,  FIPS_KEY,  1'b1, 1'b0};
    vecs[1] = '{4'd1,  FIPS_RK1,  1'b1, 1'b0};
    vecs[2] = '{4'd2,  FIPS_RK2,  1'b1, 1'b0};
    vecs[3] = '{4'd3,  FIPS_RK3,  1'b1, 1'b0};
    vecs[4] = '{4'd10, FIPS_RK10, 1'b1, 1'b0};
    vecs[5] = '{4'd11, 128'h0,    1'b0, 1'b1};
    vecs[6] = '{4'd12, 128'h0,    1'b0, 1'b1};
    vecs[7] = '{4'd15, 128'h0,    1'b0, 1'b1};

    buildSbox();
    rst = 1'b1;
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_key_ready", key_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rk_valid", rk_valid, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_rd_valid", rd_data_valid, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    checkOutput("rst_expanded_zero", |expanded_key, 0);
`ifdef AES_KEY_CACHE_EN
    checkOutput("rst_cache_hit", cache_hit, 0);
`endif
    rst = 1'b0;

    // Reads in IDLE are refused
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd0);
    tick();
    checkOutput("idle_rd_err", rd_err, 1);
    checkOutput("idle_rd_valid", rd_data_valid, 0);

    // FIPS key accepted, second key held during EXPAND, reads mid-expansion
    modelExpand(FIPS_KEY);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    tick();
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_rk_valid", rk_valid, 0);
    key_in = OTHER_KEY;
    kr_low = 0;
    for (int c = 1; c <= 10; c++) begin
      if (key_ready === 1'b0) kr_low++;
      rd_en  = (c == 3 || c == 4 || c == 6);
      rd_idx = (c == 3) ? 4'd2 : (c == 4) ? 4'd4 : 4'd5;
      if (c == 10) checkOutput("rk_valid_before_t10", rk_valid, 0);
      tick();
      if (c == 3) begin
        checkOutput("mid_rd_idx2_data", rd_data, FIPS_RK2);
        checkOutput("mid_rd_idx2_valid", rd_data_valid, 1);
      end
      if (c == 4) begin
        checkOutput("mid_rd_unwritten_err", rd_err, 1);
        checkOutput("mid_rd_unwritten_data", rd_data, 0);
        checkOutput("mid_rd_unwritten_valid", rd_data_valid, 0);
      end
      if (c == 5) begin
        checkOutput("idle_port_err", rd_err, 0);
        checkOutput("idle_port_valid", rd_data_valid, 0);
      end
      if (c == 6) begin
        checkOutput("mid_rd_idx5_data", rd_data, model_rk[5]);
        checkOutput("mid_rd_idx5_valid", rd_data_valid, 1);
      end
    end
    checkOutput("held_key_ready_low_cycles", kr_low, 10);
    checkOutput("t10_rk_valid", rk_valid, 1);
    checkOutput("t10_busy", busy, 0);
    checkOutput("t10_key_ready", key_ready, 1);
    checkOutput("t10_rk1_slice", expanded_key[255:128], FIPS_RK1);
    checkOutput("t10_rk10_slice", expanded_key[1407:1280], FIPS_RK10);

    // Same-cycle read of RK10 and accept of the held key in DONE
    rd_en  = 1'b1;
    rd_idx = 4'd10;
    tick();
    checkOutput("rd_accept_data", rd_data, FIPS_RK10);
    checkOutput("rd_accept_valid", rd_data_valid, 1);
    checkOutput("rd_accept_rk_valid", rk_valid, 0);
    checkOutput("rd_accept_busy", busy, 1);
`ifdef AES_KEY_CACHE_EN
    checkOutput("rd_accept_no_hit", cache_hit, 0);
`endif
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    lat = 0;
    while (rk_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("second_key_latency", lat, 10);
    modelExpand(OTHER_KEY);
    checkSchedule("second_key");

    // Table-driven reads against the FIPS-197 schedule
    loadKey(FIPS_KEY, lat);
    checkOutput("fips_latency", lat, 10);
    for (int v = 0; v < 8; v++) begin
      applyStimulus(1'b0, 128'h0, 1'b1, vecs[v].idx);
      tick();
      checkOutput($sformatf("vec%0d_data", v), rd_data, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_valid", v), rd_data_valid, vecs[v].exp_valid);
      checkOutput($sformatf("vec%0d_err", v), rd_err, vecs[v].exp_err);
    end
    rd_en = 1'b0;

    // Random keys against the model
    last_key = FIPS_KEY;
    for (int k = 0; k < 6; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      modelExpand(key);
      loadKey(key, lat);
      checkOutput($sformatf("rand%0d_latency", k), lat, 10);
      checkSchedule($sformatf("rand%0d", k));
      for (int r = 0; r < 4; r++) begin
        ridx = $urandom_range(0, 15);
        applyStimulus(1'b0, 128'h0, 1'b1, 4'(ridx));
        tick();
        if (ridx <= 10) begin
          checkOutput($sformatf("rand%0d_rd%0d_data", k, ridx), rd_data, model_rk[ridx]);
          checkOutput($sformatf("rand%0d_rd%0d_valid", k, ridx), rd_data_valid, 1);
        end else begin
          checkOutput($sformatf("rand%0d_rd%0d_data", k, ridx), rd_data, 0);
          checkOutput($sformatf("rand%0d_rd%0d_err", k, ridx), rd_err, 1);
        end
      end
      rd_en = 1'b0;
      last_key = key;
    end

    // Re-offer the same key in DONE
`ifdef AES_KEY_CACHE_EN
    applyStimulus(1'b1, last_key, 1'b0, 4'd0);
    tick();
    key_valid = 1'b0;
    checkOutput("cache_hit_pulse", cache_hit, 1);
    checkOutput("cache_rk_valid", rk_valid, 1);
    checkOutput("cache_busy", busy, 0);
    tick();
    checkOutput("cache_hit_end", cache_hit, 0);
    checkOutput("cache_rk_valid_after", rk_valid, 1);
    checkOutput("cache_rk10_kept", expanded_key[1407:1280], model_rk[10]);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    tick();
    key_valid = 1'b0;
    checkOutput("cache_miss_hit", cache_hit, 0);
    checkOutput("cache_miss_rk_valid", rk_valid, 0);
    lat = 0;
    while (rk_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("cache_miss_latency", lat, 10);
    checkOutput("cache_miss_rk10", expanded_key[1407:1280], FIPS_RK10);
`else
    applyStimulus(1'b1, last_key, 1'b0, 4'd0);
    tick();
    key_valid = 1'b0;
    checkOutput("reoffer_rk_valid", rk_valid, 0);
    checkOutput("reoffer_busy", busy, 1);
    lat = 0;
    while (rk_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("reoffer_latency", lat, 10);
    checkOutput("reoffer_rk10", expanded_key[1407:1280], model_rk[10]);
`endif

    // Reset in the middle of an expansion
    applyStimulus(1'b1, OTHER_KEY, 1'b0, 4'd0);
    tick();
    key_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rk_valid", rk_valid, 0);
    checkOutput("midrst_expanded_zero", |expanded_key, 0);
    checkOutput("midrst_key_ready", key_ready, 1);
    rst = 1'b0;
`ifdef AES_KEY_CACHE_EN
    applyStimulus(1'b1, 128'h0, 1'b0, 4'd0);
    tick();
    key_valid = 1'b0;
    checkOutput("idle_zero_key_no_hit", cache_hit, 0);
    checkOutput("idle_zero_key_busy", busy, 1);
    lat = 0;
    while (rk_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("idle_zero_key_latency", lat, 10);
`endif
    loadKey(FIPS_KEY, lat);
    checkOutput("post_rst_latency", lat, 10);
    checkOutput("post_rst_rk10", expanded_key[1407:1280], FIPS_RK10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
